// File: rtl/pool2.sv
// 2x2 stride-2 max pooling over CONV2_DEEP square feature maps.
// Reads each window from the conv2 result BRAM one sample at a time,
// tracks a signed running maximum, and writes one pooled sample per window.
module pool2 #(
  parameter int DATA_SIZE    = 16,
  parameter int CONV2_DEEP   = 16,
  parameter int CONV2_OUTPUT = 8,
  parameter int RD_LAT       = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pool_2_en,
  output logic                 conv_result_bram_ena,
  output logic [9:0]           conv_result_bram_addra,
  input  logic [DATA_SIZE-1:0] conv_result_bram_douta,
  output logic                 pool_bram_wea,
  output logic [7:0]           pool_bram_addra,
  output logic [DATA_SIZE-1:0] pool_bram_dina,
  output logic                 pool_2_finish
);

  localparam int          POOL_SIDE = CONV2_OUTPUT / 2;
  localparam int          WINDOWS   = CONV2_DEEP * POOL_SIDE * POOL_SIDE;
  localparam int          WIN_W     = $clog2(WINDOWS);
  localparam int unsigned WAIT_CYC  = (RD_LAT > 1) ? RD_LAT - 1 : 1;
  localparam int          WW        = $clog2(WAIT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_CAPTURE,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                 state;
  state_t                 nxt;
  logic [WW-1:0]          wcnt;
  logic [1:0]             samp;
  logic [WIN_W-1:0]       win;
  logic [DATA_SIZE-1:0]   max_q;
  logic                   last_win;
  logic [WIN_W+1:0]       src_addr;

  assign last_win = (win == WIN_W'(WINDOWS - 1));

  // Window counter is {map, pooled row, pooled col}; interleaving the sample
  // index bits yields map*64 + (2pr+s1)*8 + 2pc+s0 without multipliers.
  assign src_addr = {win[WIN_W-1:2], samp[1], win[1:0], samp[0]};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nxt;
  end

  // Next-state logic, with enable-low abort overriding any active state
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:    if (pool_2_en) nxt = S_READ;
      S_READ:    nxt = (RD_LAT > 1) ? S_WAIT : S_CAPTURE;
      S_WAIT:    if (wcnt == WW'(WAIT_CYC - 1)) nxt = S_CAPTURE;
      S_CAPTURE: nxt = (samp == 2'd3) ? S_WRITE : S_READ;
      S_WRITE:   nxt = last_win ? S_DONE : S_READ;
      S_DONE:    if (!pool_2_en) nxt = S_IDLE;
      default:   nxt = S_IDLE;
    endcase
    if (!pool_2_en && state != S_IDLE && state != S_DONE) nxt = S_IDLE;
  end

  // Counters and running max; read data is taken on the edge entering S_CAPTURE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt  <= '0;
      samp  <= '0;
      win   <= '0;
      max_q <= '0;
    end else if (nxt == S_IDLE) begin
      wcnt  <= '0;
      samp  <= '0;
      win   <= '0;
      max_q <= '0;
    end else begin
      if (state == S_WAIT)
        wcnt <= (nxt == S_WAIT) ? wcnt + 1'b1 : '0;
      if (nxt == S_CAPTURE) begin
        if (samp == 2'd0 ||
            $signed(conv_result_bram_douta) > $signed(max_q))
          max_q <= conv_result_bram_douta;
      end
      if (state == S_CAPTURE)
        samp <= samp + 2'd1;
      if (state == S_WRITE && !last_win)
        win <= win + 1'b1;
    end
  end

  // Outputs decoded from registered state, so reset forces them low at once
  always_comb begin
    conv_result_bram_ena   = (state == S_READ);
    conv_result_bram_addra = conv_result_bram_ena ? 10'(src_addr) : '0;
    pool_bram_wea          = (state == S_WRITE);
    pool_bram_addra        = pool_bram_wea ? 8'(win) : '0;
    pool_bram_dina         = pool_bram_wea ? max_q : '0;
    pool_2_finish          = (state == S_DONE);
  end

endmodule

// File: tb/tb_pool2.sv
// Self-checking bench for pool2: BRAM models on both sides, a signed-max
// reference model, and scenario tasks for reset, data, timing and abort.
module tb_pool2;

  localparam int DW = 16;

  logic          clk;
  logic          rst;
  logic          en;
  logic          ena;
  logic [9:0]    addra;
  logic [DW-1:0] douta;
  logic          wea;
  logic [7:0]    waddr;
  logic [DW-1:0] dina;
  logic          fin;

  logic [DW-1:0] mem  [0:1023];
  logic [DW-1:0] dest [0:255];
  bit            wr_seen [0:255];
  logic [DW-1:0] dq;

  int tests;
  int fails;
  int cyc;
  int rd_cnt, wr_cnt;
  int first_rd_cyc, first_wr_cyc, last_wr_cyc, first_fin_cyc;
  logic [9:0] first_rd_addr;
  bit clr;

  pool2 #(.DATA_SIZE(16), .CONV2_DEEP(16), .CONV2_OUTPUT(8), .RD_LAT(2)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .pool_2_en              (en),
    .conv_result_bram_ena   (ena),
    .conv_result_bram_addra (addra),
    .conv_result_bram_douta (douta),
    .pool_bram_wea          (wea),
    .pool_bram_addra        (waddr),
    .pool_bram_dina         (dina),
    .pool_2_finish          (fin)
  );

  always #5 clk = ~clk;

  // Source BRAM: the DUT's registered address plus one output register
  always @(posedge clk) dq <= mem[addra];
  assign douta = dq;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (clr) begin
      rd_cnt = 0; wr_cnt = 0;
      first_rd_cyc = -1; first_wr_cyc = -1; last_wr_cyc = -1; first_fin_cyc = -1;
      first_rd_addr = '1;
      for (int k = 0; k < 256; k++) begin
        wr_seen[k] = 0;
        dest[k] = '0;
      end
    end else begin
      if (ena) begin
        rd_cnt++;
        if (first_rd_cyc < 0) begin
          first_rd_cyc = cyc;
          first_rd_addr = addra;
        end
      end
      if (wea) begin
        wr_cnt++;
        wr_seen[waddr] = 1;
        dest[waddr] = dina;
        if (first_wr_cyc < 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
      end
      if (fin && first_fin_cyc < 0) first_fin_cyc = cyc;
    end
  end

  // Reference: signed maximum of the four samples of pooled output k
  function automatic logic [DW-1:0] model_max(int k);
    int base;
    logic signed [DW-1:0] m;
    logic signed [DW-1:0] v;
    int offs [4];
    offs = '{0, 1, 8, 9};
    base = (k / 16) * 64 + ((k % 16) / 4) * 16 + (k % 4) * 2;
    m = mem[base];
    for (int j = 1; j < 4; j++) begin
      v = mem[base + offs[j]];
      if (v > m) m = v;
    end
    return m;
  endfunction

  function automatic int base_of(int k);
    return (k / 16) * 64 + ((k % 16) / 4) * 16 + (k % 4) * 2;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    clr = 1;
    tick();
    clr = 0;
  endtask

  task automatic fill_random();
    for (int a = 0; a < 1024; a++) mem[a] = 16'($urandom);
  endtask

  task automatic run_to_finish(output bit done);
    done = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (fin) begin
        done = 1;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 0; en = 0;
    tick(); tick();
    tests++; if (ena !== 1'b0)   begin fails++; $display("FAIL reset_ena: got %b expected 0", ena); end
    tests++; if (addra !== '0)   begin fails++; $display("FAIL reset_addra: got %h expected 000", addra); end
    tests++; if (wea !== 1'b0)   begin fails++; $display("FAIL reset_wea: got %b expected 0", wea); end
    tests++; if (waddr !== '0)   begin fails++; $display("FAIL reset_waddr: got %h expected 00", waddr); end
    tests++; if (dina !== '0)    begin fails++; $display("FAIL reset_dina: got %h expected 0000", dina); end
    tests++; if (fin !== 1'b0)   begin fails++; $display("FAIL reset_finish: got %b expected 0", fin); end
    en = 1;
    tick(); tick();
    tests++; if (ena !== 1'b0 || wea !== 1'b0)
      begin fails++; $display("FAIL reset_hold_en: got ena=%b wea=%b expected 0/0", ena, wea); end
    en = 0;
    rst = 1;
    tick(); tick(); tick();
    tests++; if (ena !== 1'b0 || fin !== 1'b0)
      begin fails++; $display("FAIL idle_wait: got ena=%b fin=%b expected 0/0", ena, fin); end
  endtask

  task automatic test_ramp();
    bit done;
    for (int a = 0; a < 1024; a++) mem[a] = 16'(a);
    clear_log();
    en = 1;
    run_to_finish(done);
    tests++; if (!done) begin fails++; $display("FAIL ramp_timeout: got no finish expected finish"); end
    tests++; if (wr_cnt !== 256) begin fails++; $display("FAIL ramp_writes: got %0d expected 256", wr_cnt); end
    for (int k = 0; k < 256; k++) begin
      tests++;
      if (!wr_seen[k] || dest[k] !== model_max(k)) begin
        fails++; $display("FAIL ramp_dest[%0d]: got %h expected %h", k, dest[k], model_max(k));
      end
    end
    tests++; if (dest[0] !== 16'd9)      begin fails++; $display("FAIL ramp_dest0: got %0d expected 9", dest[0]); end
    tests++; if (dest[255] !== 16'd1023) begin fails++; $display("FAIL ramp_dest255: got %0d expected 1023", dest[255]); end
    tests++; if (fin !== 1'b1)           begin fails++; $display("FAIL ramp_finish: got %b expected 1", fin); end
    tick(); tick();
    tests++; if (fin !== 1'b1) begin fails++; $display("FAIL finish_hold: got %b expected 1", fin); end
    en = 0;
    tick();
    tests++; if (fin !== 1'b0) begin fails++; $display("FAIL finish_clear: got %b expected 0", fin); end
  endtask

  task automatic test_signed_position();
    bit done;
    int offs [4];
    int b;
    offs = '{0, 1, 8, 9};
    fill_random();
    b = base_of(0);
    mem[b] = 16'hFFF0; mem[b+1] = 16'hFFFD; mem[b+8] = 16'hFFF8; mem[b+9] = 16'hFFFF;
    b = base_of(1);
    for (int j = 0; j < 4; j++) mem[b + offs[j]] = 16'h8000;
    for (int j = 0; j < 4; j++) begin
      b = base_of(2 + j);
      for (int s = 0; s < 4; s++) mem[b + offs[s]] = 16'hFF00 + 16'(s);
      mem[b + offs[j]] = 16'h1234 + 16'(j);
    end
    b = base_of(6);
    mem[b] = 16'h0055; mem[b+1] = 16'h0077; mem[b+8] = 16'h0077; mem[b+9] = 16'h0011;
    clear_log();
    en = 1;
    run_to_finish(done);
    tests++; if (!done) begin fails++; $display("FAIL signed_timeout: got no finish expected finish"); end
    tests++; if (dest[0] !== 16'hFFFF) begin fails++; $display("FAIL signed_neg: got %h expected ffff", dest[0]); end
    tests++; if (dest[1] !== 16'h8000) begin fails++; $display("FAIL signed_min: got %h expected 8000", dest[1]); end
    for (int j = 0; j < 4; j++) begin
      tests++;
      if (dest[2 + j] !== 16'h1234 + 16'(j)) begin
        fails++; $display("FAIL position_slot%0d: got %h expected %h", j, dest[2 + j], 16'h1234 + 16'(j));
      end
    end
    tests++; if (dest[6] !== 16'h0077) begin fails++; $display("FAIL tie: got %h expected 0077", dest[6]); end
    for (int k = 0; k < 256; k++) begin
      tests++;
      if (!wr_seen[k] || dest[k] !== model_max(k)) begin
        fails++; $display("FAIL signed_dest[%0d]: got %h expected %h", k, dest[k], model_max(k));
      end
    end
    en = 0;
    tick();
  endtask

  task automatic test_timing();
    bit done;
    int c0;
    fill_random();
    clear_log();
    c0 = cyc;
    en = 1;
    run_to_finish(done);
    tests++; if (!done) begin fails++; $display("FAIL timing_timeout: got no finish expected finish"); end
    tests++; if (first_rd_cyc !== c0 + 1) begin fails++; $display("FAIL first_read_cycle: got %0d expected %0d", first_rd_cyc, c0 + 1); end
    tests++; if (first_rd_addr !== 10'd0) begin fails++; $display("FAIL first_read_addr: got %0d expected 0", first_rd_addr); end
    tests++; if (first_wr_cyc !== c0 + 13) begin fails++; $display("FAIL first_write_cycle: got %0d expected %0d", first_wr_cyc, c0 + 13); end
    tests++; if (last_wr_cyc !== c0 + 13 + 255 * 13) begin fails++; $display("FAIL last_write_cycle: got %0d expected %0d", last_wr_cyc, c0 + 13 + 255 * 13); end
    tests++; if (first_fin_cyc !== last_wr_cyc + 1) begin fails++; $display("FAIL finish_cycle: got %0d expected %0d", first_fin_cyc, last_wr_cyc + 1); end
    tests++; if (rd_cnt !== 1024) begin fails++; $display("FAIL read_count: got %0d expected 1024", rd_cnt); end
    tests++; if (wr_cnt !== 256)  begin fails++; $display("FAIL write_count: got %0d expected 256", wr_cnt); end
    for (int k = 0; k < 256; k++) begin
      tests++;
      if (!wr_seen[k] || dest[k] !== model_max(k)) begin
        fails++; $display("FAIL random_dest[%0d]: got %h expected %h", k, dest[k], model_max(k));
      end
    end
    en = 0;
    tick();
  endtask

  task automatic test_abort();
    bit done;
    bit reached;
    fill_random();
    clear_log();
    en = 1;
    reached = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (wr_cnt >= 37) begin
        reached = 1;
        break;
      end
    end
    tests++; if (!reached) begin fails++; $display("FAIL abort_reach: got %0d writes expected 37", wr_cnt); end
    for (int i = 0; i < 5; i++) tick();
    en = 0;
    tick();
    tests++; if (ena !== 1'b0 || wea !== 1'b0)
      begin fails++; $display("FAIL abort_outputs: got ena=%b wea=%b expected 0/0", ena, wea); end
    for (int i = 0; i < 20; i++) tick();
    tests++; if (wr_seen[37]) begin fails++; $display("FAIL abort_no_write37: got written expected not written"); end
    tests++; if (wr_cnt !== 37) begin fails++; $display("FAIL abort_write_count: got %0d expected 37", wr_cnt); end
    clear_log();
    en = 1;
    tick();
    tests++; if (ena !== 1'b1 || addra !== 10'd0)
      begin fails++; $display("FAIL restart_addr: got ena=%b addr=%0d expected 1/0", ena, addra); end
    run_to_finish(done);
    tests++; if (!done) begin fails++; $display("FAIL restart_timeout: got no finish expected finish"); end
    tests++; if (wr_cnt !== 256) begin fails++; $display("FAIL restart_writes: got %0d expected 256", wr_cnt); end
    for (int k = 0; k < 256; k++) begin
      tests++;
      if (!wr_seen[k] || dest[k] !== model_max(k)) begin
        fails++; $display("FAIL restart_dest[%0d]: got %h expected %h", k, dest[k], model_max(k));
      end
    end
    en = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    bit done;
    bit found;
    fill_random();
    clear_log();
    en = 1;
    found = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (ena && wr_cnt >= 10) begin
        found = 1;
        break;
      end
    end
    tests++; if (!found) begin fails++; $display("FAIL rstmid_reach: got %0d writes expected 10", wr_cnt); end
    #1 rst = 0;
    #1;
    tests++; if (ena !== 1'b0 || addra !== '0 || wea !== 1'b0 || waddr !== '0 || dina !== '0 || fin !== 1'b0)
      begin fails++; $display("FAIL rstmid_outputs: got ena=%b addr=%h wea=%b waddr=%h dina=%h fin=%b expected all 0",
                              ena, addra, wea, waddr, dina, fin); end
    tick(); tick(); tick();
    tests++; if (ena !== 1'b0 || wea !== 1'b0)
      begin fails++; $display("FAIL rstmid_hold: got ena=%b wea=%b expected 0/0", ena, wea); end
    clear_log();
    rst = 1;
    run_to_finish(done);
    tests++; if (!done) begin fails++; $display("FAIL rstrun_timeout: got no finish expected finish"); end
    tests++; if (first_rd_addr !== 10'd0) begin fails++; $display("FAIL rstrun_first_addr: got %0d expected 0", first_rd_addr); end
    tests++; if (wr_cnt !== 256) begin fails++; $display("FAIL rstrun_writes: got %0d expected 256", wr_cnt); end
    for (int k = 0; k < 256; k++) begin
      tests++;
      if (!wr_seen[k] || dest[k] !== model_max(k)) begin
        fails++; $display("FAIL rstrun_dest[%0d]: got %h expected %h", k, dest[k], model_max(k));
      end
    end
    en = 0;
    tick();
  endtask

  initial begin
    clk = 0;
    rst = 0;
    en = 0;
    clr = 0;
    cyc = 0;
    tests = 0;
    fails = 0;
    for (int a = 0; a < 1024; a++) mem[a] = '0;
    test_reset();
    test_ramp();
    test_signed_position();
    test_timing();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pool2.md
POOL2 -- requirements
Module: pool2

Interface
REQ-001 Parameter DATA_SIZE, default 16, width of one fixed-point sample.
REQ-002 Parameter CONV2_DEEP, default 16, number of feature maps.
REQ-003 Parameter CONV2_OUTPUT, default 8, side length of each input feature map.
REQ-004 Parameter RD_LAT, default 2, source BRAM read latency in cycles.
REQ-005 Port clk, input, 1, single clock; all logic on rising edge.
REQ-006 Port rst, input, 1, asynchronous active-low reset.
REQ-007 Port pool_2_en, input, 1, level enable; high runs the block, low aborts or idles it.
REQ-008 Port conv_result_bram_ena, output, 1, read enable to the conv2 result BRAM.
REQ-009 Port conv_result_bram_addra, output, 10, read address into the conv2 result BRAM.
REQ-010 Port conv_result_bram_douta, input, DATA_SIZE, read data from the conv2 result BRAM (two's complement).
REQ-011 Port pool_bram_wea, output, 1, write strobe to the pooled-result BRAM.
REQ-012 Port pool_bram_addra, output, 8, write address into the pooled-result BRAM.
REQ-013 Port pool_bram_dina, output, DATA_SIZE, write data into the pooled-result BRAM.
REQ-014 Port pool_2_finish, output, 1, high when all maps are pooled.

Function
REQ-015 The block SHALL perform 2x2, stride-2 max pooling on CONV2_DEEP maps of 8x8, producing CONV2_DEEP maps of 4x4.
REQ-016 Source layout: map f, row r, column c is at address f*64 + r*8 + c.
REQ-017 Destination layout: map f, pooled row pr, pooled column pc is at address f*16 + pr*4 + pc.
REQ-018 Processing order: f ascending; within f, pr ascending; within pr, pc ascending.
REQ-019 Window read order: (2pr,2pc), (2pr,2pc+1), (2pr+1,2pc), (2pr+1,2pc+1).
REQ-020 Each read: ena=1 and addra registered on edge E; douta sampled on edge E+RD_LAT; next read address registered on edge E+RD_LAT+1.
REQ-021 conv_result_bram_ena SHALL be high only on the cycles that present a read address, and low otherwise.
REQ-022 The first window sample SHALL load the max register directly, with no comparison against zero.
REQ-023 Each later sample SHALL replace the max only if it is strictly greater under a signed DATA_SIZE comparison; ties keep the earlier sample.
REQ-024 No ReLU, saturation, or width change is applied; output equals one input sample bit-exactly.
REQ-025 After the fourth sample, the block SHALL spend one cycle with wea=1, addra=destination and dina=max; wea is low on all other cycles.
REQ-026 Window period SHALL be 4*(RD_LAT+1)+1 cycles (13 at the default), with no gap between windows.
REQ-027 FSM states SHALL be S_IDLE, S_READ, S_WAIT, S_CAPTURE, S_WRITE and S_DONE.
REQ-028 S_IDLE goes to S_READ on the first edge with pool_2_en=1.
REQ-029 S_READ goes to S_WAIT.
REQ-030 S_WAIT runs RD_LAT-1 cycles (skipped if RD_LAT=1), then goes to S_CAPTURE.
REQ-031 S_CAPTURE goes to S_READ if the window is incomplete, otherwise to S_WRITE.
REQ-032 S_WRITE goes to S_READ for the next window, or to S_DONE after destination address 255.
REQ-033 In S_DONE, pool_2_finish SHALL be 1 and held until pool_2_en=0, then the FSM returns to S_IDLE with finish=0.
REQ-034 pool_2_en=0 in any state other than S_IDLE or S_DONE SHALL abort to S_IDLE on the next edge.
REQ-035 On abort: ena=0, wea=0, counters cleared, no partial write; the next run restarts at f=0.
REQ-036 Address counters SHALL NOT wrap; the run ends exactly after map CONV2_DEEP-1, window (3,3).

Reset
REQ-037 While rst=0, the FSM SHALL be in S_IDLE with all counters and the max register at 0.
REQ-038 While rst=0, all outputs SHALL be 0: ena, addra, wea, pool_bram_addra, dina and finish.
REQ-039 Reset assertion mid-run SHALL take effect immediately, with no further BRAM access.
REQ-040 After reset release, the block SHALL wait in S_IDLE for pool_2_en.

Verification
REQ-041 Ramp test: source mem[a]=a, en=1 -> dest[k] = f*64 + (2pr+1)*8 + 2pc + 1; dest[0]=9, dest[255]=1023, finish=1.
REQ-042 Signed test: window 0xFFF0, 0xFFFD, 0xFFF8, 0xFFFF -> 0xFFFF; window 0x8000 x4 -> 0x8000 (no clamp to 0).
REQ-043 Position and tie test: max placed in each of the 4 slots -> correct value; equal maxima -> the same value is written.
REQ-044 Timing test: en rises -> first read address 0 on next edge, first wea 13 cycles later, 256 writes total, finish exactly 1 cycle after the last write.
REQ-045 Abort test: en low during window 37 -> no write to 37, ena and wea low next cycle; en high again -> reads restart at address 0.
REQ-046 Reset test: rst low mid-window -> outputs 0 immediately; after release with en=1 -> full correct run.
